// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Generates the fetch address for a dual-issue fetch unit that returns the
// pair {fetch_pc, fetch_pc+4} every cycle. It handles three kinds of control
// transfer:
//   * exceptions/interrupts (exc_req): immediate redirect to exc_pc.
//   * branches/J (br_req): redirect to br_target. If the delay slot is not yet
//     inside the current fetch pair, one more sequential pair is fetched first
//     and the target is parked in tgt.
//   * register jumps (jr_req): like a branch, but the target (jr_data) may
//     arrive late. In that case fetch is suspended until jr_data_ok.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   exc_req      exception redirect request (single-cycle pulse)
//   exc_pc       exception vector
//   stall        hard stall: hold fetch_pc, state and tgt
//   br_req       branch/J request, held until redir_ack
//   br_target    branch/J target, stable while br_req is high
//   slot_fetched delay slot already inside the current fetch pair
//   jr_req       register-jump request, held until redir_ack
//   jr_data      register-jump target
//   jr_data_ok   jr_data is valid this cycle
//   fetch_pc     registered fetch address
//   fetch_valid  fetch_pc is a real fetch this cycle
//   flush_if     registered pulse: discard the IF/ID pair returned this cycle
//   redir_ack    combinational pulse: br_req/jr_req accepted this cycle
//   addr_err     registered: last loaded target was not word aligned
// -----------------------------------------------------------------------------
module pc_redirect_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        stall,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        slot_fetched,
  input  logic        jr_req,
  input  logic [31:0] jr_data,
  input  logic        jr_data_ok,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic        redir_ack,
  output logic        addr_err
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] PAIR_STEP = 32'd8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,  // sequential fetch, new requests accepted
    SLOT   = 2'd1,  // delay-slot pair being fetched, tgt loads next
    WAITJR = 2'd2   // register jump accepted, target not yet available
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] pc_d;
  logic        flush_d;
  logic        aerr_d;

  // Target chosen for a new request accepted in RUN: br_req wins over jr_req.
  logic        take_br;
  logic        take_jr;
  logic [31:0] req_target;
  logic        req_target_ok;

  assign take_br       = br_req;
  assign take_jr       = !br_req && jr_req;
  assign req_target    = take_br ? br_target : jr_data;
  // A register jump without valid data cannot be resolved this cycle.
  assign req_target_ok = take_br || (take_jr && jr_data_ok);

  // NOTE: every signal assigned in this always_comb receives a default first,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    pc_d      = fetch_pc;
    flush_d   = 1'b0;
    aerr_d    = addr_err;
    redir_ack = 1'b0;

    if (reset) begin
      // Register block applies the reset values; nothing is acknowledged.
      redir_ack = 1'b0;
    end else if (exc_req) begin
      // Exception beats everything, including a parked target or a pending
      // register jump; held requests are simply seen again in RUN.
      pc_d    = exc_pc;
      state_d = RUN;
      flush_d = 1'b1;
      aerr_d  = |exc_pc[1:0];
    end else if (stall) begin
      // Hold everything; defaults already express this.
      flush_d = 1'b0;
    end else begin
      unique case (state_q)
        SLOT: begin
          // Delay slot pair has been issued; now go to the parked target.
          pc_d    = tgt_q;
          flush_d = 1'b1;
          state_d = RUN;
          aerr_d  = |tgt_q[1:0];
        end

        WAITJR: begin
          if (jr_data_ok) begin
            pc_d    = jr_data;
            flush_d = 1'b1;
            state_d = RUN;
            aerr_d  = |jr_data[1:0];
          end
        end

        default: begin  // RUN
          if (take_br || take_jr) begin
            redir_ack = 1'b1;
            if (req_target_ok) begin
              aerr_d = |req_target[1:0];
              if (slot_fetched) begin
                // Delay slot is already in flight: redirect immediately.
                pc_d    = req_target;
                flush_d = 1'b1;
              end else begin
                // Fetch the pair holding the delay slot, then redirect.
                tgt_d   = req_target;
                pc_d    = fetch_pc + PAIR_STEP;
                state_d = SLOT;
              end
            end else begin
              state_d = WAITJR;
            end
          end else begin
            // Natural 32-bit wrap from 0xFFFF_FFF8 to 0.
            pc_d = fetch_pc + PAIR_STEP;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      tgt_q    <= '0;
      fetch_pc <= RESET_PC;
      flush_if <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      fetch_pc <= pc_d;
      flush_if <= flush_d;
      addr_err <= aerr_d;
    end
  end

  // No real fetch while waiting for a register-jump target or while reset
  // is being applied.
  assign fetch_valid = !reset && (state_q != WAITJR);

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset, with ports named clk and reset as elsewhere in the codebase.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 The block SHALL have port exc_req, input, 1 bit: exception/interrupt redirect request, single-cycle.
REQ-005 The block SHALL have port exc_pc, input, 32 bits: exception vector.
REQ-006 The block SHALL have port stall, input, 1 bit: hard stall; hold fetch_pc.
REQ-007 The block SHALL have port br_req, input, 1 bit: branch/J redirect request, held high until redir_ack.
REQ-008 The block SHALL have port br_target, input, 32 bits: branch/J target, stable while br_req is high.
REQ-009 The block SHALL have port slot_fetched, input, 1 bit: delay slot is already inside the current fetch pair; sampled with the request.
REQ-010 The block SHALL have port jr_req, input, 1 bit: register-jump request, held high until redir_ack.
REQ-011 The block SHALL have port jr_data, input, 32 bits: register-jump target.
REQ-012 The block SHALL have port jr_data_ok, input, 1 bit: jr_data is valid this cycle.
REQ-013 The block SHALL have port fetch_pc, output, 32 bits: registered fetch address; the fetch pair is {fetch_pc, fetch_pc+4}.
REQ-014 The block SHALL have port fetch_valid, output, 1 bit: fetch_pc is a real fetch this cycle.
REQ-015 The block SHALL have port flush_if, output, 1 bit: registered pulse; the IF/ID pair returned this cycle is discarded.
REQ-016 The block SHALL have port redir_ack, output, 1 bit: combinational pulse; br_req/jr_req accepted this cycle.
REQ-017 The block SHALL have port addr_err, output, 1 bit: registered; the last loaded target had bits[1:0] != 0.

Function
REQ-018 The state machine SHALL have three states: RUN, SLOT and WAITJR, plus an internal 32-bit target register tgt.
REQ-019 Per-cycle priority SHALL be: reset > exc_req > stall > pending redirect (SLOT/WAITJR) > new request (br_req > jr_req) > sequential.
REQ-020 On exc_req, in any state: next fetch_pc = exc_pc; state -> RUN; tgt discarded; flush_if = 1 next cycle; no redir_ack; any held br_req/jr_req is re-evaluated afterwards.
REQ-021 On stall without exc_req: fetch_pc, state and tgt SHALL hold; redir_ack = 0; flush_if = 0.
REQ-022 In sequential operation (RUN, no request): next fetch_pc = fetch_pc + 8, with 32-bit wrap (0xFFFF_FFF8 -> 0x0000_0000).
REQ-023 For br_req in RUN with slot_fetched = 1: redir_ack = 1; next fetch_pc = br_target; flush_if = 1 next cycle; state stays RUN.
REQ-024 For br_req in RUN with slot_fetched = 0: redir_ack = 1; tgt <= br_target; next fetch_pc = fetch_pc + 8 (delay-slot fetch); state -> SLOT.
REQ-025 In SLOT without stall: next fetch_pc = tgt; flush_if = 1 next cycle; state -> RUN.
REQ-026 For jr_req in RUN with jr_data_ok = 1: the request SHALL be handled as br_req with target jr_data.
REQ-027 For jr_req in RUN with jr_data_ok = 0: redir_ack = 1; state -> WAITJR; fetch_pc holds; fetch_valid = 0.
REQ-028 In WAITJR: the block SHALL wait for jr_data_ok; on jr_data_ok, next fetch_pc = jr_data, flush_if = 1 next cycle, state -> RUN.
REQ-029 br_req/jr_req arriving in SLOT or WAITJR SHALL be ignored (no ack) until the state returns to RUN.
REQ-030 If br_req and jr_req are asserted together, br_req SHALL win and jr_req stays unacked.
REQ-031 fetch_valid SHALL be 1 except in WAITJR and during the reset cycle.
REQ-032 addr_err SHALL update on every target or exc_pc load and otherwise hold its value.

Reset
REQ-033 While reset = 1 at a clk edge: fetch_pc = 0xBFC0_0000; state = RUN; tgt = 0; flush_if = 0; addr_err = 0; fetch_valid = 0 during the reset cycle.
REQ-034 Reset SHALL override exc_req and stall, and SHALL abort SLOT/WAITJR mid-operation with no late redirect.

Verification
REQ-035 Scenario: reset, then 3 free cycles -> fetch_pc = BFC00000, BFC00008, BFC00010; fetch_valid = 1 after reset.
REQ-036 Scenario: br_req, target 0x80001000, slot_fetched = 0, at pc BFC00010 -> ack; pc BFC00018, then 80001000 with flush_if = 1, then 80001008.
REQ-037 Scenario: jr_req with jr_data_ok low for 3 cycles, then jr_data = 0x80002004 -> pc held, fetch_valid = 0 for 3 cycles; then pc 80002004, flush_if = 1, addr_err = 0.
REQ-038 Scenario: SLOT state with stall for 2 cycles, then exc_req with exc_pc = 0xBFC00380 -> pc held for 2 cycles; then pc BFC00380, state RUN, and the pending target is never loaded.
REQ-039 Scenario: br_req and jr_req together; br_target = 0x80000002 -> br accepted, addr_err = 1, jr_req still pending and acked on the next RUN cycle.
REQ-040 Scenario: reset asserted during WAITJR with jr_data_ok high the same cycle -> fetch_pc = BFC00000, no redirect afterwards.
